div_pipe8: RTL and testbench

DIV_PIPE8 -- requirements
Module: div_pipe8

---
 rtl/div_pipe8.sv | 139 +++++++++++++
 tb/tb_div_pipe8.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_pipe8.sv
// Eight-stage restoring divider (RISC-V DIV/DIVU/REM/REMU), four quotient bits
// resolved per stage; one op accepted per cycle, results in issue order.
module div_pipe8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_signed,
  input  logic        in_get_rem,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic [6:0]  div_busy_0,
  output logic [6:0]  div_busy_1,
  output logic [6:0]  div_busy_2,
  output logic [6:0]  div_busy_3,
  output logic [6:0]  div_busy_4,
  output logic [6:0]  div_busy_5,
  output logic [6:0]  div_busy_6,
  output logic [6:0]  div_busy_7,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data
);

  typedef struct packed {
    logic        valid;
    logic        sgn;
    logic        get_rem;
    logic [4:0]  rd;
    logic [31:0] dvs;
    logic [31:0] prem;
    logic [31:0] pquo;
    logic        q_neg;
    logic        r_neg;
    logic        dz;
    logic        ovf;
  } stage_t;

  stage_t      stage_r     [0:7];
  stage_t      stage_nxt_s [0:7];
  logic        dnd_neg_s;
  logic        dvs_neg_s;
  logic [31:0] dnd_mag_s;
  logic [31:0] dvs_mag_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;

  // pquo starts as the dividend and shifts left, quotient bits entering at the LSB
  function automatic logic [63:0] div_step4(input logic [31:0] prem,
                                            input logic [31:0] pquo,
                                            input logic [31:0] dvs);
    logic [32:0] trial;
    logic [31:0] r;
    logic [31:0] q;
    r = prem;
    q = pquo;
    for (int i = 0; i < 32'sd4; i++) begin
      trial = {r, q[31]};
      q     = {q[30:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        trial = trial - {1'b0, dvs};
        q[0]  = 1'b1;
      end else begin
        q[0]  = 1'b0;
      end
      r = trial[31:0];
    end
    return {r, q};
  endfunction

  // Operand magnitudes and signs of the op at the issue port
  always_comb begin
    dnd_neg_s = in_signed & in_dividend[31];
    dvs_neg_s = in_signed & in_divisor[31];
    dnd_mag_s = dnd_neg_s ? (32'd0 - in_dividend) : in_dividend;
    dvs_mag_s = dvs_neg_s ? (32'd0 - in_divisor) : in_divisor;
  end

  // Next state of every stage: four division iterations on its predecessor
  always_comb begin
    logic [63:0] step_v;
    stage_nxt_s[0]         = '0;
    stage_nxt_s[0].valid   = in_valid;
    stage_nxt_s[0].sgn     = in_signed;
    stage_nxt_s[0].get_rem = in_get_rem;
    stage_nxt_s[0].rd      = in_rd;
    stage_nxt_s[0].dvs     = dvs_mag_s;
    stage_nxt_s[0].q_neg   = dnd_neg_s ^ dvs_neg_s;
    stage_nxt_s[0].r_neg   = dnd_neg_s;
    stage_nxt_s[0].dz      = (in_divisor == 32'd0);
    stage_nxt_s[0].ovf     = in_signed & (in_dividend == 32'h8000_0000) &
                             (in_divisor == 32'hFFFF_FFFF);
    step_v                 = div_step4(32'd0, dnd_mag_s, dvs_mag_s);
    stage_nxt_s[0].prem    = step_v[63:32];
    stage_nxt_s[0].pquo    = step_v[31:0];
    for (int k = 1; k < 32'sd8; k++) begin
      stage_nxt_s[k]      = stage_r[k-1];
      step_v              = div_step4(stage_r[k-1].prem, stage_r[k-1].pquo, stage_r[k-1].dvs);
      stage_nxt_s[k].prem = step_v[63:32];
      stage_nxt_s[k].pquo = step_v[31:0];
    end
  end

  // Pipeline registers; reset drops every op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32'sd8; k++) stage_r[k] <= '0;
    end else begin
      for (int k = 0; k < 32'sd8; k++) stage_r[k] <= stage_nxt_s[k];
    end
  end

  assign div_busy_0 = stage_r[0].valid ? {1'b1, stage_r[0].get_rem, stage_r[0].rd} : 7'd0;
  assign div_busy_1 = stage_r[1].valid ? {1'b1, stage_r[1].get_rem, stage_r[1].rd} : 7'd0;
  assign div_busy_2 = stage_r[2].valid ? {1'b1, stage_r[2].get_rem, stage_r[2].rd} : 7'd0;
  assign div_busy_3 = stage_r[3].valid ? {1'b1, stage_r[3].get_rem, stage_r[3].rd} : 7'd0;
  assign div_busy_4 = stage_r[4].valid ? {1'b1, stage_r[4].get_rem, stage_r[4].rd} : 7'd0;
  assign div_busy_5 = stage_r[5].valid ? {1'b1, stage_r[5].get_rem, stage_r[5].rd} : 7'd0;
  assign div_busy_6 = stage_r[6].valid ? {1'b1, stage_r[6].get_rem, stage_r[6].rd} : 7'd0;
  assign div_busy_7 = stage_r[7].valid ? {1'b1, stage_r[7].get_rem, stage_r[7].rd} : 7'd0;

  // Sign fixup and special-case override on the last stage
  always_comb begin
    q_fix_s = stage_r[7].q_neg ? (32'd0 - stage_r[7].pquo) : stage_r[7].pquo;
    r_fix_s = stage_r[7].r_neg ? (32'd0 - stage_r[7].prem) : stage_r[7].prem;
    if (stage_r[7].dz) begin
      q_fix_s = 32'hFFFF_FFFF;
    end else if (stage_r[7].ovf) begin
      q_fix_s = 32'h8000_0000;
      r_fix_s = 32'd0;
    end else begin
      q_fix_s = q_fix_s;
    end
    out_valid = stage_r[7].valid;
    out_rd    = stage_r[7].valid ? stage_r[7].rd : 5'd0;
    out_data  = stage_r[7].valid ? (stage_r[7].get_rem ? r_fix_s : q_fix_s) : 32'd0;
  end

endmodule

// File: tb/tb_div_pipe8.sv
// Self-checking bench for div_pipe8: directed spec cases, randomized ops against
// an arithmetic reference, busy scoreboard and mid-flight reset.
module tb_div_pipe8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_signed;
  logic        in_get_rem;
  logic [4:0]  in_rd;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [6:0]  div_busy_0, div_busy_1, div_busy_2, div_busy_3;
  logic [6:0]  div_busy_4, div_busy_5, div_busy_6, div_busy_7;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [6:0]  busy_s [0:7];

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   fails;

  div_pipe8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_signed(in_signed),
    .in_get_rem(in_get_rem), .in_rd(in_rd), .in_dividend(in_dividend),
    .in_divisor(in_divisor),
    .div_busy_0(div_busy_0), .div_busy_1(div_busy_1), .div_busy_2(div_busy_2),
    .div_busy_3(div_busy_3), .div_busy_4(div_busy_4), .div_busy_5(div_busy_5),
    .div_busy_6(div_busy_6), .div_busy_7(div_busy_7),
    .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data)
  );

  assign busy_s[0] = div_busy_0;
  assign busy_s[1] = div_busy_1;
  assign busy_s[2] = div_busy_2;
  assign busy_s[3] = div_busy_3;
  assign busy_s[4] = div_busy_4;
  assign busy_s[5] = div_busy_5;
  assign busy_s[6] = div_busy_6;
  assign busy_s[7] = div_busy_7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M-extension semantics written directly with language arithmetic
  function automatic logic [31:0] ref_div(input bit sgn, input bit get_rem,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return get_rem ? a : 32'hFFFF_FFFF;
    if (!sgn) return get_rem ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return get_rem ? 32'd0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    return get_rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'($urandom_range(0, 20));
      4: v = 32'd0 - 32'($urandom_range(1, 20));
      5: v = 32'($urandom_range(0, 65535));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Called at a negedge; applies one cycle of input and returns at the next negedge
  task automatic drive(input bit v, input bit s, input bit r, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_data);
    exp_t e;
    in_valid    = v;
    in_signed   = s;
    in_get_rem  = r;
    in_rd       = rd;
    in_dividend = a;
    in_divisor  = b;
    @(posedge clk);
    cyc++;
    if (v) begin
      e.due  = cyc + 7;
      e.rd   = rd;
      e.data = exp_data;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_signed = 1'b0; in_get_rem = 1'b0; in_rd = 5'd0;
    in_dividend = 32'd0; in_divisor = 32'd0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy_s[k] !== 7'd0) begin
        fails++;
        $display("FAIL reset_busy%0d got=%h want=00", k, busy_s[k]);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_out got v=%b rd=%0d data=%h want 0/0/0", out_valid, out_rd, out_data);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_directed();
    logic [31:0] da [0:10];
    logic [31:0] db [0:10];
    logic [31:0] dx [0:10];
    bit          ds [0:10];
    bit          dr [0:10];
    da = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
           32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    db = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dx = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
           32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
    ds = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    dr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 21; i++) begin
      if (i < 11) drive(1'b1, ds[i], dr[i], 5'(i), da[i], db[i], dx[i]);
      else        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
      checks++;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        if (out_valid !== 1'b1 || out_rd !== exp_q[0].rd || out_data !== exp_q[0].data) begin
          fails++;
          $display("FAIL directed_result cyc=%0d got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                   cyc, out_valid, out_rd, out_data, exp_q[0].rd, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else begin
        if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0) begin
          fails++;
          $display("FAIL directed_idle cyc=%0d got v=%b rd=%0d data=%h want 0/0/0",
                   cyc, out_valid, out_rd, out_data);
        end
      end
    end
  endtask

  task automatic test_random();
    bit          v, s, r;
    logic [4:0]  rd;
    logic [31:0] a, b;
    for (int i = 0; i < 310; i++) begin
      v  = (i < 300) && ($urandom_range(0, 9) < 7);
      s  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      a  = pick_operand();
      b  = pick_operand();
      drive(v, s, r, rd, a, b, ref_div(s, r, a, b));
      checks++;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        if (out_valid !== 1'b1 || out_rd !== exp_q[0].rd || out_data !== exp_q[0].data) begin
          fails++;
          $display("FAIL random_result cyc=%0d got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                   cyc, out_valid, out_rd, out_data, exp_q[0].rd, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else begin
        if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0) begin
          fails++;
          $display("FAIL random_idle cyc=%0d got v=%b rd=%0d data=%h want 0/0/0",
                   cyc, out_valid, out_rd, out_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit          rem_of [1:8];
    logic [31:0] a, b;
    bit          s;
    for (int i = 1; i <= 18; i++) begin
      if (i <= 8) begin
        s         = 1'($urandom_range(0, 1));
        rem_of[i] = 1'($urandom_range(0, 1));
        a         = pick_operand();
        b         = pick_operand();
        drive(1'b1, s, rem_of[i], 5'(i), a, b, ref_div(s, rem_of[i], a, b));
      end else begin
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
      end
      if (i == 8) begin
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (busy_s[k] !== {1'b1, rem_of[8-k], 5'(8 - k)}) begin
            fails++;
            $display("FAIL b2b_busy%0d got=%h want=%h", k, busy_s[k],
                     {1'b1, rem_of[8-k], 5'(8 - k)});
          end
        end
      end
      checks++;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        if (out_valid !== 1'b1 || out_rd !== exp_q[0].rd || out_data !== exp_q[0].data) begin
          fails++;
          $display("FAIL b2b_result cyc=%0d got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                   cyc, out_valid, out_rd, out_data, exp_q[0].rd, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else begin
        if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0) begin
          fails++;
          $display("FAIL b2b_idle cyc=%0d got v=%b rd=%0d data=%h want 0/0/0",
                   cyc, out_valid, out_rd, out_data);
        end
      end
    end
  endtask

  task automatic test_rst_midflight();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'(20 + i), 32'd100 + 32'(i), 32'd3, 32'd0);
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy_s[k] !== 7'd0) begin
        fails++;
        $display("FAIL rst_busy%0d got=%h want=00", k, busy_s[k]);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL rst_out got v=%b rd=%0d data=%h want 0/0/0", out_valid, out_rd, out_data);
    end
    exp_q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i == 12) drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
      else         drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
      checks++;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        if (out_valid !== 1'b1 || out_rd !== exp_q[0].rd || out_data !== exp_q[0].data) begin
          fails++;
          $display("FAIL rst_fresh cyc=%0d got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                   cyc, out_valid, out_rd, out_data, exp_q[0].rd, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else begin
        if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0) begin
          fails++;
          $display("FAIL rst_idle cyc=%0d got v=%b rd=%0d data=%h want 0/0/0",
                   cyc, out_valid, out_rd, out_data);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    cyc    = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_rst_midflight();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_results got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
